pp_buf_ctrl: RTL
================

# pp_buf_ctrl

Ping-pong controller for one feature-map or guard column buffer, placed between the PE matrix write-back port and the downstream consumer. It sequences a `ping_pong_buffer`. The producer fills the write bank and the consumer drains the read bank. The block swaps banks only when the write bank holds a complete frame and the read bank is fully drained. One instance is used per column per buffer type.

## Interface
- `BIT_LENGTH`, default 8: data width (8 for feature map, 6 for guard).
- `DEPTH`, default 256: words per bank.
- `AW`, default $clog2(DEPTH): address width.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_valid`  in  1  producer word valid.
- `wr_ready`  out  1  producer may write; equals !w_full.
- `wr_data`  in  BIT_LENGTH  producer word.
- `wr_last`  in  1  accepted word is the last of the frame.
- `rd_valid`  out  1  output word valid.
- `rd_ready`  in  1  consumer accepts word.
- `rd_data`  out  BIT_LENGTH  output word.
- `rd_last`  out  1  output word is the last of the frame.
- `ena`, `wea`  out  1  bank write strobe; both equal the write handshake.
- `addra`  out  AW  write address.
- `dina`  out  BIT_LENGTH  equals wr_data.
- `enb`  out  1  bank read strobe.
- `addrb`  out  AW  read address.
- `doutb`  in  BIT_LENGTH  read data, valid the cycle after enb.
- `ping_pong`  out  1  bank select: write bank = ping_pong, read bank = !ping_pong.
- `swap`  out  1  one-cycle pulse in the first cycle ping_pong holds its new value.

## Operation
- Write counter `wr_cnt` (AW+1 bits).
- A write is accepted when wr_valid and wr_ready are both high.
- On an accepted write: ena=wea=1, addra=wr_cnt[AW-1:0], and wr_cnt increments.
- w_full is set when the accepted word has wr_last=1, or when it is the DEPTH-th word. In the DEPTH-th-word case the frame is forced closed at length DEPTH. A frame always has at least one word.
- Read state consists of rd_len, rd_ptr (AW+1 bits), in_flight (1 bit) and a 2-entry output FIFO of {data, last}.
- enb asserts when all three hold:
  - rd_ptr < rd_len;
  - in_flight is low, or the FIFO will have room for the returning word;
  - fifo_count + in_flight − pop < 2, where pop = rd_valid && rd_ready.
- On enb: addrb=rd_ptr[AW-1:0], rd_ptr increments, and in_flight is set the next cycle.
- The cycle after enb, doutb is pushed into the FIFO with last=(ptr_issued == rd_len−1).
- rd_valid = FIFO not empty. rd_data and rd_last come from the FIFO head.
- Swap condition (registered): w_full && rd_ptr==rd_len && !in_flight && FIFO empty. On swap:
  - ping_pong toggles;
  - rd_len := wr_cnt, rd_ptr := 0, wr_cnt := 0, w_full := 0;
  - swap pulses.
- While w_full is set and the swap condition is false, wr_ready stays low and the producer stalls.
- Reset values:
  - ping_pong=0, wr_cnt=0, w_full=0, rd_len=0, rd_ptr=0, in_flight=0, FIFO empty;
  - outputs: wr_ready=1, rd_valid=0, rd_last=0, rd_data=0, enb=0, ena=wea=0, swap=0.
- Reset mid-operation discards both banks' contents and all counters. Memory contents need not be cleared.

## Timing
- Write path is combinational to the bank: zero latency, one word per cycle.
- Last word accepted in cycle t: w_full is high in t+1, and the swap edge is the end of t+1 if the read side is idle.
- After that swap, ping_pong and swap are updated in t+2, and wr_ready is high again in t+2.
- The first enb is in t+2 and the first rd_valid is in t+4 (enb → doutb → FIFO).
- With rd_ready held high, the steady-state read rate is one word per cycle.
- A swap is never concurrent with enb or in_flight.
- A write in the cycle w_full is set is impossible, because wr_ready is already low.
- rd_valid stays high with stable data while rd_ready is low.

## Test plan
- Single frame: write 4 words (0x11..0x14, wr_last on the 4th) in cycles 1–4, rd_ready=1. Expect swap in cycle 6, ping_pong=1, and rd_data 0x11..0x14 on consecutive cycles from cycle 8 with rd_last on 0x14.
- Overlap: write frame A (3 words), then immediately frame B (5 words) while A drains. Expect B written to bank 0 concurrently with reads of bank 1. Expect the second swap only after A's last word is accepted.
- Consumer stall: rd_ready=0 for 10 cycles mid-frame. Expect rd_valid held with constant data, enb suppressed once the FIFO plus in-flight word total 2, and no lost or duplicated words after release.
- Back-pressure to producer: rd_ready=0 while the second frame completes. Expect wr_ready=0 until the read bank drains, and no swap before then.
- Overflow: write DEPTH words with no wr_last. Expect forced frame close, rd_len=DEPTH, and rd_last on word DEPTH−1 (addrb wraps to 0 only on the next frame).
- Reset mid-read: assert rst_n=0 during drain. Expect all outputs at reset values immediately, ping_pong=0, and a subsequent 2-word frame read back correctly.

Source files
------------

// File: rtl/pp_buf_ctrl.sv
// rtl/pp_buf_ctrl.sv - ping-pong bank sequencer between PE write-back and a downstream consumer
module pp_buf_ctrl #(
   parameter int BIT_LENGTH = 8,
   parameter int DEPTH      = 256,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [BIT_LENGTH-1:0] wr_data,
   input  logic                  wr_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [BIT_LENGTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  ena,
   output logic                  wea,
   output logic [AW-1:0]         addra,
   output logic [BIT_LENGTH-1:0] dina,
   output logic                  enb,
   output logic [AW-1:0]         addrb,
   input  logic [BIT_LENGTH-1:0] doutb,
   output logic                  ping_pong,
   output logic                  swap
);

   localparam int unsigned   LAST_I   = DEPTH - 1;
   localparam logic [AW:0]   LAST_IDX = LAST_I[AW:0];
   localparam logic [AW:0]   ONE      = {{AW{1'b0}}, 1'b1};

   logic [AW:0]         wr_cnt_q, wr_cnt_d;
   logic                w_full_q, w_full_d;
   logic                ping_pong_q, ping_pong_d;
   logic                swap_q, swap_d;
   logic [AW:0]         rd_len_q, rd_len_d;
   logic [AW:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]         ptr_issued_q, ptr_issued_d;
   logic                in_flight_q, in_flight_d;
   logic [BIT_LENGTH:0] fifo_q [2];
   logic [BIT_LENGTH:0] fifo_d [2];
   logic                fifo_wp_q, fifo_wp_d;
   logic                fifo_rp_q, fifo_rp_d;
   logic [1:0]          fifo_cnt_q, fifo_cnt_d;

   logic                wr_fire;
   logic                pop;
   logic                push_last;
   logic                swap_cond;
   logic                rd_issue;
   logic [2:0]          occ_next;

   always_comb begin
      wr_fire   = wr_valid && !w_full_q;
      pop       = (fifo_cnt_q != 2'd0) && rd_ready;
      push_last = (ptr_issued_q == (rd_len_q - ONE));
      swap_cond = w_full_q && (rd_ptr_q == rd_len_q) && !in_flight_q && (fifo_cnt_q == 2'd0);
      // Occupancy once this cycle's pop and the returning in-flight word have settled
      occ_next  = {1'b0, fifo_cnt_q} + {2'b00, in_flight_q} - {2'b00, pop};
      rd_issue  = (rd_ptr_q < rd_len_q)
               && (!in_flight_q || (({1'b0, fifo_cnt_q} - {2'b00, pop}) < 3'd2))
               && (occ_next < 3'd2);

      wr_cnt_d     = wr_cnt_q;
      w_full_d     = w_full_q;
      ping_pong_d  = ping_pong_q;
      swap_d       = swap_cond;
      rd_len_d     = rd_len_q;
      rd_ptr_d     = rd_ptr_q;
      ptr_issued_d = ptr_issued_q;
      in_flight_d  = rd_issue;
      fifo_d       = fifo_q;
      fifo_wp_d    = fifo_wp_q;
      fifo_rp_d    = fifo_rp_q;
      fifo_cnt_d   = fifo_cnt_q + {1'b0, in_flight_q} - {1'b0, pop};

      if (wr_fire) begin
         wr_cnt_d = wr_cnt_q + ONE;
         if (wr_last || (wr_cnt_q == LAST_IDX)) begin
            w_full_d = 1'b1;
         end
      end

      if (rd_issue) begin
         rd_ptr_d     = rd_ptr_q + ONE;
         ptr_issued_d = rd_ptr_q;
      end

      if (in_flight_q) begin
         fifo_d[fifo_wp_q] = {push_last, doutb};
         fifo_wp_d         = !fifo_wp_q;
      end
      if (pop) begin
         fifo_rp_d = !fifo_rp_q;
      end

      // Swap only happens with the read side idle, so it never collides with a read issue
      if (swap_cond) begin
         ping_pong_d = !ping_pong_q;
         rd_len_d    = wr_cnt_q;
         rd_ptr_d    = '0;
         wr_cnt_d    = '0;
         w_full_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q     <= '0;
         w_full_q     <= 1'b0;
         ping_pong_q  <= 1'b0;
         swap_q       <= 1'b0;
         rd_len_q     <= '0;
         rd_ptr_q     <= '0;
         ptr_issued_q <= '0;
         in_flight_q  <= 1'b0;
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
         fifo_wp_q    <= 1'b0;
         fifo_rp_q    <= 1'b0;
         fifo_cnt_q   <= 2'd0;
      end else begin
         wr_cnt_q     <= wr_cnt_d;
         w_full_q     <= w_full_d;
         ping_pong_q  <= ping_pong_d;
         swap_q       <= swap_d;
         rd_len_q     <= rd_len_d;
         rd_ptr_q     <= rd_ptr_d;
         ptr_issued_q <= ptr_issued_d;
         in_flight_q  <= in_flight_d;
         fifo_q       <= fifo_d;
         fifo_wp_q    <= fifo_wp_d;
         fifo_rp_q    <= fifo_rp_d;
         fifo_cnt_q   <= fifo_cnt_d;
      end
   end

   always_comb begin
      wr_ready  = !w_full_q;
      ena       = wr_fire;
      wea       = wr_fire;
      addra     = wr_cnt_q[AW-1:0];
      dina      = wr_data;
      enb       = rd_issue;
      addrb     = rd_ptr_q[AW-1:0];
      rd_valid  = (fifo_cnt_q != 2'd0);
      rd_data   = rd_valid ? fifo_q[fifo_rp_q][BIT_LENGTH-1:0] : '0;
      rd_last   = rd_valid ? fifo_q[fifo_rp_q][BIT_LENGTH] : 1'b0;
      ping_pong = ping_pong_q;
      swap      = swap_q;
   end

endmodule
